msx_spi_controller: RTL



---
 rtl/msx_spi_controller.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/msx_spi_controller.sv
// MSX cartridge SPI port controller: Z80 data/config I/O ports driving one
// 8-bit mode-0 SPI master with selectable slow (card init) and fast clock rates.
module msx_spi_controller #(
    parameter int FAST_HALF = 2,
    parameter int SLOW_HALF = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_select,
    input  logic       config_select,
    input  logic       rd_L,
    input  logic       wr_L,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_L,
    output logic       busy
);

    localparam int MAX_HALF = (FAST_HALF > SLOW_HALF) ? FAST_HALF : SLOW_HALF;
    localparam int CW       = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;
    localparam logic [CW-1:0] FAST_M1 = CW'(FAST_HALF - 1);
    localparam logic [CW-1:0] SLOW_M1 = CW'(SLOW_HALF - 1);

    // Strobe index: 0 = data write, 1 = config write, 2 = config read
    localparam int N_STB = 3;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    logic [N_STB-1:0] strobe_raw;
    logic [N_STB-1:0] strobe_sync;
    logic [N_STB-1:0] prev_reg;
    logic [N_STB-1:0] strobe_rise;
    logic             data_wr_rise;
    logic             cfg_wr_rise;
    logic             cfg_rd_rise;

    state_t        state_reg, state_next;
    logic [CW-1:0] div_cnt_reg, div_cnt_next;
    logic [CW-1:0] half_m1_reg, half_m1_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    tx_shift_reg, tx_shift_next;
    logic [7:0]    rx_shift_reg, rx_shift_next;
    logic [7:0]    rx_data_reg, rx_data_next;
    logic          sclk_reg, sclk_next;
    logic          mosi_reg, mosi_next;
    logic          busy_reg, busy_next;
    logic          cs_en_reg, cs_en_next;
    logic          slow_reg, slow_next;
    logic          overrun_reg, overrun_next;
    logic          ovr_hold_reg, ovr_hold_next;

    assign strobe_raw = {~config_select & ~rd_L,
                         ~config_select & ~wr_L,
                         ~spi_select    & ~wr_L};

    genvar gi;
    generate
        for (gi = 0; gi < N_STB; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= strobe_raw[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign strobe_sync[gi] = sync_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= strobe_sync;
        end
    end

    assign strobe_rise  = strobe_sync & ~prev_reg;
    assign data_wr_rise = strobe_rise[0];
    assign cfg_wr_rise  = strobe_rise[1];
    assign cfg_rd_rise  = strobe_rise[2];

    always_comb begin
        state_next    = state_reg;
        div_cnt_next  = div_cnt_reg;
        half_m1_next  = half_m1_reg;
        bit_cnt_next  = bit_cnt_reg;
        tx_shift_next = tx_shift_reg;
        rx_shift_next = rx_shift_reg;
        rx_data_next  = rx_data_reg;
        sclk_next     = sclk_reg;
        mosi_next     = mosi_reg;
        busy_next     = busy_reg;
        cs_en_next    = cs_en_reg;
        slow_next     = slow_reg;
        overrun_next  = overrun_reg;
        ovr_hold_next = ovr_hold_reg;

        if (cfg_wr_rise) begin
            cs_en_next = d_in[0];
            slow_next  = d_in[1];
        end

        // The read strobe is still low when the clear lands, so the cleared
        // flag stays visible on the bus until the read strobe goes away.
        if (cfg_rd_rise) begin
            ovr_hold_next = overrun_reg;
            overrun_next  = 1'b0;
        end else if (!strobe_sync[2]) begin
            ovr_hold_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (data_wr_rise) begin
                    tx_shift_next = d_in;
                    bit_cnt_next  = 3'd0;
                    div_cnt_next  = '0;
                    half_m1_next  = slow_reg ? SLOW_M1 : FAST_M1;
                    busy_next     = 1'b1;
                    mosi_next     = d_in[7];
                    sclk_next     = 1'b0;
                    state_next    = LOW;
                end
            end
            LOW: begin
                if (div_cnt_reg == half_m1_reg) begin
                    div_cnt_next = '0;
                    sclk_next    = 1'b1;
                    state_next   = HIGH;
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            HIGH: begin
                if (div_cnt_reg == '0) begin
                    rx_shift_next = {rx_shift_reg[6:0], spi_miso};
                end
                if (div_cnt_reg == half_m1_reg) begin
                    div_cnt_next = '0;
                    sclk_next    = 1'b0;
                    if (bit_cnt_reg != 3'd7) begin
                        tx_shift_next = {tx_shift_reg[6:0], 1'b1};
                        mosi_next     = tx_shift_reg[6];
                        bit_cnt_next  = bit_cnt_reg + 3'd1;
                        state_next    = LOW;
                    end else begin
                        mosi_next  = 1'b1;
                        state_next = DONE;
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            DONE: begin
                rx_data_next = rx_shift_reg;
                busy_next    = 1'b0;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (data_wr_rise && (state_reg != IDLE)) begin
            overrun_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            div_cnt_reg  <= '0;
            half_m1_reg  <= FAST_M1;
            bit_cnt_reg  <= 3'd0;
            tx_shift_reg <= 8'hFF;
            rx_shift_reg <= 8'hFF;
            rx_data_reg  <= 8'hFF;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            cs_en_reg    <= 1'b0;
            slow_reg     <= 1'b1;
            overrun_reg  <= 1'b0;
            ovr_hold_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_cnt_reg  <= div_cnt_next;
            half_m1_reg  <= half_m1_next;
            bit_cnt_reg  <= bit_cnt_next;
            tx_shift_reg <= tx_shift_next;
            rx_shift_reg <= rx_shift_next;
            rx_data_reg  <= rx_data_next;
            sclk_reg     <= sclk_next;
            mosi_reg     <= mosi_next;
            busy_reg     <= busy_next;
            cs_en_reg    <= cs_en_next;
            slow_reg     <= slow_next;
            overrun_reg  <= overrun_next;
            ovr_hold_reg <= ovr_hold_next;
        end
    end

    assign spi_sclk = sclk_reg;
    assign spi_mosi = mosi_reg;
    assign spi_cs_L = ~cs_en_reg;
    assign busy     = busy_reg;

    // Bus read path stays combinational on the raw strobes for Z80 timing
    assign d_oe = (~spi_select | ~config_select) & ~rd_L;

    always_comb begin
        d_out = 8'h00;
        if (d_oe) begin
            if (!spi_select) begin
                d_out = rx_data_reg;
            end else begin
                d_out = {busy_reg, overrun_reg | ovr_hold_reg, 4'b0000, slow_reg, cs_en_reg};
            end
        end
    end

endmodule
